// File: rtl/dcache_wb_if.sv
// rtl/dcache_wb_if.sv - MEM request/response and DM block channel bundle for dcache_wb
// Purpose: groups the MEM-stage request/response signals and the DM block
//          transfer signals of the data cache into one bundle.
// Modports:
//   slave  - the cache: takes MEM requests and DM responses, drives results
//            and DM requests.
//   master - the environment (MEM stage plus data memory).
interface dcache_wb_if;
   // MEM stage -> cache
   logic [31:0]  data_address_2DC;
   logic         read_2DC;
   logic         write_2DC;
   logic [31:0]  data_write_2DC;
   logic [1:0]   data_write_size_2DC;
   logic         flush_2DC;
   // cache -> MEM stage
   logic [31:0]  data_read_fDC;
   logic         data_valid_fDC;
   logic         flush_done_fDC;
   // cache -> data memory
   logic [31:0]  data_address_2DM;
   logic [255:0] block_write_2DM;
   logic         dBlkRead;
   logic         dBlkWrite;
   // data memory -> cache
   logic [255:0] block_read_fDM;
   logic         block_read_fDM_valid;
   logic         block_write_fDM_valid;

   modport slave (
      input  data_address_2DC, read_2DC, write_2DC, data_write_2DC,
             data_write_size_2DC, flush_2DC,
             block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
      output data_read_fDC, data_valid_fDC, flush_done_fDC,
             data_address_2DM, block_write_2DM, dBlkRead, dBlkWrite
   );

   modport master (
      output data_address_2DC, read_2DC, write_2DC, data_write_2DC,
             data_write_size_2DC, flush_2DC,
             block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
      input  data_read_fDC, data_valid_fDC, flush_done_fDC,
             data_address_2DM, block_write_2DM, dBlkRead, dBlkWrite
   );
endinterface

// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped write-back write-allocate data cache
// Purpose: serves MEM-stage word reads and 1-4 byte writes from LINES lines of
//          256 bits, stalls MEM on misses, exchanges whole blocks with data
//          memory, and writes back / invalidates every line on a flush request.
// Ports:
//   CLK   - single clock, all state changes on the rising edge
//   RESET - synchronous, active-high; invalidates all lines, abandons transfers
//   bus   - dcache_wb_if.slave: MEM request/response and DM block channel
module dcache_wb #(
   parameter int LINES = 32,
   parameter int TAGW  = 27 - $clog2(LINES)
) (
   input  logic       CLK,
   input  logic       RESET,
   dcache_wb_if.slave bus
);
   localparam int IW = $clog2(LINES);
   localparam logic [IW-1:0] LAST_LINE = IW'(LINES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WB, S_FILL, S_FL_SCAN, S_FL_WB, S_FL_DONE
   } state_t;

   state_t           state;
   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAGW-1:0]  tag_q  [LINES];
   logic [255:0]     data_q [LINES];
   logic [IW-1:0]    scan_q;
   logic             blk_read_q;
   logic             blk_write_q;
   logic             flush_done_q;
   logic [31:0]      dm_addr_q;

   // Request address fields
   logic [TAGW-1:0] req_tag;
   logic [IW-1:0]   req_idx;
   logic [2:0]      req_word;
   logic [1:0]      req_off;
   assign req_tag  = bus.data_address_2DC[31:5+IW];
   assign req_idx  = bus.data_address_2DC[4+IW:5];
   assign req_word = bus.data_address_2DC[4:2];
   assign req_off  = bus.data_address_2DC[1:0];

   logic [7:0]  word_lsb;
   logic [31:0] cur_word;
   logic        line_hit;
   assign word_lsb = {req_word, 5'b0};
   assign cur_word = data_q[req_idx][word_lsb +: 32];
   assign line_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // Byte merge: lanes from the start offset up to (exclusive) offset+count;
   // the 3-bit end may exceed 3, in which case the extra lanes simply vanish.
   logic [2:0]  nbytes;
   logic [2:0]  lane_lo;
   logic [2:0]  lane_end;
   logic [31:0] merged_word;
   always_comb begin
      nbytes      = (bus.data_write_size_2DC == 2'd0) ? 3'd4 : {1'b0, bus.data_write_size_2DC};
      lane_lo     = {1'b0, req_off};
      lane_end    = lane_lo + nbytes;
      merged_word = cur_word;
      for (int b = 0; b < 4; b++) begin
         if ((3'(b) >= lane_lo) && (3'(b) < lane_end)) begin
            merged_word[31-8*b -: 8] = bus.data_write_2DC[31-8*b -: 8];
         end
      end
   end

   // Hit path is combinational so hits complete in the request cycle.
   logic        data_valid_c;
   logic [31:0] data_read_c;
   always_comb begin
      data_valid_c = 1'b0;
      data_read_c  = '0;
      if (state == S_IDLE) begin
         if (bus.flush_2DC) begin
            data_valid_c = 1'b0;
         end else if (bus.write_2DC || bus.read_2DC) begin
            data_valid_c = line_hit;
            if (!bus.write_2DC && line_hit) begin
               data_read_c = cur_word;
            end
         end else begin
            data_valid_c = 1'b1;
         end
      end
   end

   // Victim block: the scanned line during a flush, else the requested index
   // (MEM holds its address stable while stalled).
   logic [IW-1:0] blk_idx;
   assign blk_idx = (state == S_FL_SCAN || state == S_FL_WB) ? scan_q : req_idx;

   assign bus.data_read_fDC    = data_read_c;
   assign bus.data_valid_fDC   = data_valid_c;
   assign bus.flush_done_fDC   = flush_done_q;
   assign bus.data_address_2DM = dm_addr_q;
   assign bus.block_write_2DM  = data_q[blk_idx];
   assign bus.dBlkRead         = blk_read_q;
   assign bus.dBlkWrite        = blk_write_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= S_IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         scan_q       <= '0;
         blk_read_q   <= 1'b0;
         blk_write_q  <= 1'b0;
         flush_done_q <= 1'b0;
         dm_addr_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.flush_2DC) begin
                  scan_q <= '0;
                  state  <= S_FL_SCAN;
               end else if (bus.write_2DC || bus.read_2DC) begin
                  if (line_hit) begin
                     if (bus.write_2DC) begin
                        data_q[req_idx][word_lsb +: 32] <= merged_word;
                        dirty_q[req_idx]                <= 1'b1;
                     end
                  end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                     blk_write_q <= 1'b1;
                     dm_addr_q   <= {tag_q[req_idx], req_idx, 5'b0};
                     state       <= S_WB;
                  end else begin
                     blk_read_q <= 1'b1;
                     dm_addr_q  <= {req_tag, req_idx, 5'b0};
                     state      <= S_FILL;
                  end
               end
            end
            S_WB: begin
               if (bus.block_write_fDM_valid) begin
                  blk_write_q <= 1'b0;
                  blk_read_q  <= 1'b1;
                  dm_addr_q   <= {req_tag, req_idx, 5'b0};
                  state       <= S_FILL;
               end
            end
            S_FILL: begin
               // The request is replayed in IDLE and then hits.
               if (bus.block_read_fDM_valid) begin
                  data_q[req_idx]  <= bus.block_read_fDM;
                  tag_q[req_idx]   <= req_tag;
                  valid_q[req_idx] <= 1'b1;
                  dirty_q[req_idx] <= 1'b0;
                  blk_read_q       <= 1'b0;
                  state            <= S_IDLE;
               end
            end
            S_FL_SCAN: begin
               if (valid_q[scan_q] && dirty_q[scan_q]) begin
                  blk_write_q <= 1'b1;
                  dm_addr_q   <= {tag_q[scan_q], scan_q, 5'b0};
                  state       <= S_FL_WB;
               end else begin
                  valid_q[scan_q] <= 1'b0;
                  dirty_q[scan_q] <= 1'b0;
                  if (scan_q == LAST_LINE) begin
                     flush_done_q <= 1'b1;
                     state        <= S_FL_DONE;
                  end else begin
                     scan_q <= scan_q + IW'(1);
                  end
               end
            end
            S_FL_WB: begin
               if (bus.block_write_fDM_valid) begin
                  blk_write_q     <= 1'b0;
                  valid_q[scan_q] <= 1'b0;
                  dirty_q[scan_q] <= 1'b0;
                  if (scan_q == LAST_LINE) begin
                     flush_done_q <= 1'b1;
                     state        <= S_FL_DONE;
                  end else begin
                     scan_q <= scan_q + IW'(1);
                     state  <= S_FL_SCAN;
                  end
               end
            end
            S_FL_DONE: begin
               if (!bus.flush_2DC) begin
                  flush_done_q <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - self-checking bench for dcache_wb against a flat-memory reference
module tb_dcache_wb;
   localparam int LINES = 32;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   dcache_wb_if bus ();

   dcache_wb #(.LINES(LINES)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   // Data-memory responder state
   int          mem_lat  = 0;
   int          wait_cnt = 0;
   int          n_fill   = 0;
   int          n_wb     = 0;
   logic [31:0]  fill_q [$];
   logic [31:0]  wb_q   [$];
   logic [255:0] wbd_q  [$];
   logic [255:0] dm_mem [logic [26:0]];

   // Reference: mdm = what memory should hold, gold = what the CPU should see,
   // m_* = which block each direct-mapped slot should hold.
   logic [255:0] mdm  [logic [26:0]];
   logic [31:0]  gold [logic [29:0]];
   bit           m_v   [LINES];
   bit           m_d   [LINES];
   logic [26:0]  m_blk [LINES];

   function automatic logic [31:0] init_word(input logic [29:0] wa);
      return {wa[15:0], ~wa[15:0]} ^ 32'h5A3C96E1;
   endfunction

   function automatic logic [255:0] init_block(input logic [26:0] ba);
      logic [255:0] b;
      for (int w = 0; w < 8; w++) b[32*w +: 32] = init_word({ba, 3'(w)});
      return b;
   endfunction

   function automatic logic [255:0] dm_block(input logic [26:0] ba);
      return dm_mem.exists(ba) ? dm_mem[ba] : init_block(ba);
   endfunction

   function automatic logic [255:0] mdm_block(input logic [26:0] ba);
      return mdm.exists(ba) ? mdm[ba] : init_block(ba);
   endfunction

   function automatic logic [31:0] gold_word(input logic [29:0] wa);
      logic [255:0] b;
      if (gold.exists(wa)) return gold[wa];
      b = mdm_block(wa[29:3]);
      return b[32*wa[2:0] +: 32];
   endfunction

   function automatic logic [255:0] gold_block(input logic [26:0] ba);
      logic [255:0] b;
      for (int w = 0; w < 8; w++) b[32*w +: 32] = gold_word({ba, 3'(w)});
      return b;
   endfunction

   // Big-endian byte write: lane b is bits [31-8b:24-8b]; lanes past 3 dropped.
   task automatic gold_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
      logic [31:0] w;
      int n;
      int b;
      n = (sz == 2'd0) ? 4 : int'(sz);
      w = gold_word(a[31:2]);
      for (int k = 0; k < n; k++) begin
         b = int'(a[1:0]) + k;
         if (b <= 3) w[31-8*b -: 8] = wd[31-8*b -: 8];
      end
      gold[a[31:2]] = w;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) begin
         m_v[i] = 1'b0;
         m_d[i] = 1'b0;
      end
      gold.delete();
      fill_q.delete();
      wb_q.delete();
      wbd_q.delete();
   endtask

   // Memory responder: answers after mem_lat waiting cycles (0 = first cycle).
   always begin
      @(posedge CLK);
      #1;
      bus.block_read_fDM_valid  = 1'b0;
      bus.block_write_fDM_valid = 1'b0;
      if (!RESET && (bus.dBlkRead || bus.dBlkWrite)) begin
         if (wait_cnt >= mem_lat) begin
            wait_cnt = 0;
            if (bus.dBlkWrite) begin
               dm_mem[bus.data_address_2DM[31:5]] = bus.block_write_2DM;
               wb_q.push_back(bus.data_address_2DM);
               wbd_q.push_back(bus.block_write_2DM);
               n_wb++;
               bus.block_write_fDM_valid = 1'b1;
            end else begin
               bus.block_read_fDM = dm_block(bus.data_address_2DM[31:5]);
               fill_q.push_back(bus.data_address_2DM);
               n_fill++;
               bus.block_read_fDM_valid = 1'b1;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // One MEM access; called and returns at posedge+1.
   task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input int lat, output logic [31:0] rd);
      int          idx;
      bit          hit;
      bit          dirty;
      int          exp_cyc;
      int          cyc;
      bit          got;
      int          f0;
      int          w0;
      logic [31:0] vaddr;
      logic [255:0] vblk;
      idx   = int'(a[9:5]);
      hit   = m_v[idx] && (m_blk[idx] == a[31:5]);
      dirty = !hit && m_v[idx] && m_d[idx];
      vaddr = {m_blk[idx], 5'b0};
      vblk  = gold_block(m_blk[idx]);
      exp_cyc = hit ? 0 : (dirty ? 3 + 2*lat : 2 + lat);
      mem_lat = lat;
      f0 = n_fill;
      w0 = n_wb;
      rd = '0;
      bus.data_address_2DC    = a;
      bus.read_2DC            = !wr;
      bus.write_2DC           = wr;
      bus.data_write_2DC      = wd;
      bus.data_write_size_2DC = sz;
      #1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 300) begin
         if (bus.data_valid_fDC) begin
            got = 1'b1;
            rd  = bus.data_read_fDC;
         end else begin
            @(posedge CLK);
            #2;
            cyc++;
         end
      end
      chk("acc_valid", 256'(got), 256'(1));
      chk("acc_latency", 256'(cyc), 256'(exp_cyc));
      if (!wr) chk("acc_rdata", rd, gold_word(a[31:2]));
      chk("acc_fills", 256'(n_fill - f0), 256'(hit ? 0 : 1));
      chk("acc_wbs", 256'(n_wb - w0), 256'(dirty ? 1 : 0));
      while (fill_q.size() > 0) chk("acc_fill_addr", fill_q.pop_front(), {a[31:5], 5'b0});
      while (wb_q.size() > 0) begin
         chk("acc_wb_addr", wb_q.pop_front(), vaddr);
         chk("acc_wb_data", wbd_q.pop_front(), vblk);
      end
      if (dirty) mdm[vaddr[31:5]] = vblk;
      if (wr) gold_write(a, wd, sz);
      if (!hit) begin
         m_v[idx]   = 1'b1;
         m_d[idx]   = 1'b0;
         m_blk[idx] = a[31:5];
      end
      if (wr) m_d[idx] = 1'b1;
      @(posedge CLK);
      #1;
      bus.read_2DC  = 1'b0;
      bus.write_2DC = 1'b0;
   endtask

   task automatic do_flush(input int lat);
      logic [31:0]  expa [$];
      logic [255:0] expd [$];
      int           ndirty;
      int           cyc;
      int           w0;
      for (int i = 0; i < LINES; i++) begin
         if (m_v[i] && m_d[i]) begin
            expa.push_back({m_blk[i], 5'b0});
            expd.push_back(gold_block(m_blk[i]));
            mdm[m_blk[i]] = gold_block(m_blk[i]);
         end
         m_v[i] = 1'b0;
         m_d[i] = 1'b0;
      end
      ndirty  = expa.size();
      mem_lat = lat;
      w0      = n_wb;
      bus.flush_2DC = 1'b1;
      #1;
      cyc = 0;
      while (!bus.flush_done_fDC && cyc < 2000) begin
         @(posedge CLK);
         #2;
         cyc++;
      end
      chk("flush_cycles", 256'(cyc), 256'(1 + LINES + ndirty * (1 + lat)));
      chk("flush_wbs", 256'(n_wb - w0), 256'(ndirty));
      while (wb_q.size() > 0) begin
         chk("flush_wb_addr", wb_q.pop_front(), (expa.size() > 0) ? expa.pop_front() : 32'hFFFFFFFF);
         chk("flush_wb_data", wbd_q.pop_front(), (expd.size() > 0) ? expd.pop_front() : '1);
      end
      @(posedge CLK);
      #1;
      bus.flush_2DC = 1'b0;
      @(posedge CLK);
      #2;
      chk("flush_done_drop", 256'(bus.flush_done_fDC), 256'(0));
      chk("flush_idle_valid", 256'(bus.data_valid_fDC), 256'(1));
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0]  rd;
      logic [31:0]  a;
      logic [31:0]  wd;
      logic [1:0]   sz;
      logic [255:0] blk;
      bit           wr;
      int           cyc;

      bus.data_address_2DC      = '0;
      bus.read_2DC              = 1'b0;
      bus.write_2DC             = 1'b0;
      bus.data_write_2DC        = '0;
      bus.data_write_size_2DC   = '0;
      bus.flush_2DC             = 1'b0;
      bus.block_read_fDM        = '0;
      bus.block_read_fDM_valid  = 1'b0;
      bus.block_write_fDM_valid = 1'b0;
      model_reset();

      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
      #1;
      chk("rst_valid", 256'(bus.data_valid_fDC), 256'(1));
      chk("rst_rdata", 256'(bus.data_read_fDC), 256'(0));
      chk("rst_blkread", 256'(bus.dBlkRead), 256'(0));
      chk("rst_blkwrite", 256'(bus.dBlkWrite), 256'(0));
      chk("rst_flushdone", 256'(bus.flush_done_fDC), 256'(0));
      chk("rst_dmaddr", 256'(bus.data_address_2DM), 256'(0));
      @(posedge CLK);
      #1;

      // Clean read miss, memory answers 3 cycles after the request rises
      blk = init_block(27'h80);
      blk[63:32] = 32'hDEADBEEF;
      dm_mem[27'h80] = blk;
      mdm[27'h80]    = blk;
      access(1'b0, 32'h00001004, 32'h0, 2'd0, 3, rd);
      chk("t1_miss_data", 256'(rd), 256'(32'hDEADBEEF));
      access(1'b0, 32'h00001004, 32'h0, 2'd0, 3, rd);
      chk("t1_hit_data", 256'(rd), 256'(32'hDEADBEEF));

      // Byte write hit, then read back the merged word
      access(1'b1, 32'h00001006, 32'h0000AB00, 2'd1, 0, rd);
      access(1'b0, 32'h00001004, 32'h0, 2'd0, 0, rd);
      chk("t2_merged", 256'(rd), 256'(32'hDEADABEF));

      // Dirty conflict on the same index
      access(1'b0, 32'h00001404, 32'h0, 2'd0, 1, rd);
      chk("t3_mem_word1", 256'(dm_mem[27'h80][63:32]), 256'(32'hDEADABEF));

      // Memory valid in the first FILL cycle
      access(1'b0, 32'h00002044, 32'h0, 2'd0, 0, rd);

      // Random mix with frequent conflicts
      for (int i = 0; i < 150; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 3'($urandom), 2'b00};
         wd = $urandom;
         sz = 2'($urandom);
         if (wr) a[1:0] = 2'($urandom);
         access(wr, a, wd, sz, $urandom_range(0, 2), rd);
      end
      do_flush(1);

      // Flush with exactly two dirty lines (indices 0 and 5)
      access(1'b1, 32'h00004000, 32'h12345678, 2'd0, 0, rd);
      access(1'b1, 32'h000040A0, 32'hCAFE0000, 2'd2, 1, rd);
      do_flush(1);
      foreach (mdm[k]) chk("t4_dm_contents", dm_block(k), mdm[k]);
      access(1'b0, 32'h00004000, 32'h0, 2'd0, 0, rd);
      access(1'b0, 32'h000040A0, 32'h0, 2'd0, 0, rd);

      // Reset while FILL is outstanding
      access(1'b0, 32'h00000104, 32'h0, 2'd0, 0, rd);
      access(1'b0, 32'h00000104, 32'h0, 2'd0, 0, rd);
      mem_lat = 50;
      bus.data_address_2DC = 32'h00000520;
      bus.read_2DC         = 1'b1;
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
      #1;
      chk("t6_fill_req", 256'(bus.dBlkRead), 256'(1));
      RESET        = 1'b1;
      bus.read_2DC = 1'b0;
      @(posedge CLK);
      #2;
      chk("t6_fill_blkread", 256'(bus.dBlkRead), 256'(0));
      chk("t6_fill_blkwrite", 256'(bus.dBlkWrite), 256'(0));
      chk("t6_fill_valid", 256'(bus.data_valid_fDC), 256'(1));
      chk("t6_fill_dmaddr", 256'(bus.data_address_2DM), 256'(0));
      RESET = 1'b0;
      model_reset();
      @(posedge CLK);
      #1;
      access(1'b0, 32'h00000104, 32'h0, 2'd0, 1, rd);

      // Reset while a flush writeback is outstanding; the dirty write is lost
      access(1'b1, 32'h00000308, 32'h11223344, 2'd0, 0, rd);
      mem_lat = 50;
      bus.flush_2DC = 1'b1;
      #1;
      cyc = 0;
      while (!bus.dBlkWrite && cyc < 100) begin
         @(posedge CLK);
         #2;
         cyc++;
      end
      chk("t6_flwb_req", 256'(bus.dBlkWrite), 256'(1));
      RESET         = 1'b1;
      bus.flush_2DC = 1'b0;
      @(posedge CLK);
      #2;
      chk("t6_flwb_blkwrite", 256'(bus.dBlkWrite), 256'(0));
      chk("t6_flwb_blkread", 256'(bus.dBlkRead), 256'(0));
      chk("t6_flwb_flushdone", 256'(bus.flush_done_fDC), 256'(0));
      chk("t6_flwb_valid", 256'(bus.data_valid_fDC), 256'(1));
      RESET = 1'b0;
      model_reset();
      @(posedge CLK);
      #1;
      access(1'b0, 32'h00000308, 32'h0, 2'd0, 0, rd);
      access(1'b0, 32'h00001004, 32'h0, 2'd0, 2, rd);
      chk("t6_persisted", 256'(rd), 256'(32'hDEADABEF));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
